// File: rtl/laser_pkg.sv
// Shared types and line-level constants for the laser frame transmitter.
package laser_pkg;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Laser drive levels for the idle line, the start bit and the stop bit.
  localparam logic LASER_IDLE  = 1'b0;
  localparam logic LASER_START = 1'b1;
  localparam logic LASER_STOP  = 1'b0;

endpackage : laser_pkg

// File: rtl/laser_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// line bit. Held at zero by restart so a new frame always starts on a clean
// bit boundary.
module laser_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;

  // Period counter with explicit wrap so non-power-of-two periods work.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      count_reg <= '0;
    end else if (count_reg == LAST_COUNT) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign bit_tick = (count_reg == LAST_COUNT);

endmodule : laser_tx_bit_timer

// File: rtl/laser_tx.sv
// Laser frame transmitter: accepts a word on a valid/ready handshake and
// sends start bit (1), DATA_WIDTH payload bits LSB first, then stop bit (0),
// each held for CLKS_PER_BIT cycles. A word offered during the last stop
// cycle is chained on with no idle gap.
module laser_tx
  import laser_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  laser_out,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_t             state_reg;
  tx_state_t             state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IW-1:0]         bit_idx_reg;
  logic                  laser_reg;
  logic                  bit_tick;
  logic                  accept;
  logic                  last_payload_bit;

  // The timer idles at zero so the first start-bit cycle begins its count at 0.
  laser_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .restart  (state_reg == IDLE),
    .bit_tick (bit_tick)
  );

  assign accept           = data_valid && data_ready;
  assign last_payload_bit = (bit_idx_reg == LAST_IDX);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: every phase except IDLE advances on a bit-period tick.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick && last_payload_bit) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) state_next = accept ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: ready only when the line is free or about to be free.
  always_comb begin
    busy       = (state_reg != IDLE);
    done       = (state_reg == STOP) && bit_tick;
    data_ready = !reset && ((state_reg == IDLE) || ((state_reg == STOP) && bit_tick));
  end

  // Datapath: word capture, LSB-first shifting, bit index and registered laser drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      laser_reg   <= LASER_IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg   <= data_in;
            bit_idx_reg <= '0;
            laser_reg   <= LASER_START;
          end
        end
        START: begin
          if (bit_tick) begin
            laser_reg   <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (last_payload_bit) begin
              laser_reg <= LASER_STOP;
            end else begin
              laser_reg   <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (accept) begin
              shift_reg   <= data_in;
              bit_idx_reg <= '0;
              laser_reg   <= LASER_START;
            end else begin
              laser_reg <= LASER_IDLE;
            end
          end
        end
        default: laser_reg <= LASER_IDLE;
      endcase
    end
  end

  assign laser_out = laser_reg;

endmodule : laser_tx

// File: tb/tb_laser_tx.sv
// Testbench for laser_tx: frame-position reference model checked every cycle,
// plus directed frames with hand-written waveform patterns.
module tb_laser_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FL  = (DW + 2) * CPB;

  logic          clock;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          laser_out;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  laser_tx #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .laser_out  (laser_out),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current frame (-1 = idle line).
  int          m_pos = -1;
  logic [DW-1:0] m_word = '0;

  function automatic logic model_laser(input int pos, input logic [DW-1:0] w);
    int b;
    if (pos < 0) return 1'b0;
    b = pos / CPB;
    if (b == 0) return 1'b1;
    if (b == DW + 1) return 1'b0;
    return w[b-1];
  endfunction

  always @(posedge clock) begin
    bit rdy;
    rdy = (reset === 1'b0) && (m_pos < 0 || m_pos == FL - 1);
    if (reset) begin
      m_pos = -1;
    end else if (data_valid && rdy) begin
      m_pos  = 0;
      m_word = data_in;
    end else if (m_pos >= 0) begin
      m_pos = (m_pos == FL - 1) ? -1 : m_pos + 1;
    end
  end

  always @(negedge clock) begin
    chk("model_laser", laser_out, model_laser(m_pos, m_word));
    chk("model_busy", busy, m_pos >= 0);
    chk("model_done", done, m_pos == FL - 1);
    chk("model_ready", data_ready, (reset === 1'b0) && (m_pos < 0 || m_pos == FL - 1));
  end

  // One isolated frame; pat[i] is the expected level of line bit i.
  task automatic run_frame(input string tag, input logic [DW-1:0] w, input logic [9:0] pat);
    @(posedge clock); #1;
    data_valid = 1'b1;
    data_in    = w;
    @(posedge clock); #1;
    data_valid = 1'b0;
    for (int k = 1; k <= FL + 1; k++) begin
      @(negedge clock);
      if (k <= FL) begin
        chk({tag, "_laser"}, laser_out, pat[(k-1)/CPB]);
        chk({tag, "_done"}, done, k == FL);
      end else begin
        chk({tag, "_busy_after"}, busy, 1'b0);
      end
    end
    $display("frame %s word=%02h checked", tag, w);
  endtask

  initial begin
    logic [9:0] pat_a5;
    logic [9:0] pat_00;
    logic [9:0] pat_ff;
    logic [9:0] pat_3c;
    logic [9:0] pat_81;
    pat_a5 = 10'b0101001011;
    pat_00 = 10'b0000000001;
    pat_ff = 10'b0111111111;
    pat_3c = 10'b0001111001;
    pat_81 = 10'b0100000011;

    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_laser", laser_out, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ready", data_ready, 1'b1);
    $display("reset idle state checked");

    run_frame("a5", 8'hA5, pat_a5);

    // Back-to-back: 0x00 then 0xFF with data_valid held high.
    @(posedge clock); #1;
    data_valid = 1'b1;
    data_in    = 8'h00;
    @(posedge clock); #1;
    data_in = 8'hFF;
    for (int k = 1; k <= 2 * FL + 1; k++) begin
      @(negedge clock);
      if (k <= FL) chk("b2b_laser1", laser_out, pat_00[(k-1)/CPB]);
      else if (k <= 2 * FL) chk("b2b_laser2", laser_out, pat_ff[(k-1-FL)/CPB]);
      if (k <= 2 * FL) begin
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_done", done, (k == FL) || (k == 2 * FL));
      end else begin
        chk("b2b_busy_after", busy, 1'b0);
      end
      if (k == FL) chk("b2b_ready", data_ready, 1'b1);
      if (k == FL + 1) data_valid = 1'b0;
    end
    $display("back-to-back 00/ff checked");

    // Input churn while not ready must not disturb the frame.
    @(posedge clock); #1;
    data_valid = 1'b1;
    data_in    = 8'h3C;
    @(posedge clock); #1;
    data_in = DW'($urandom);
    for (int k = 1; k <= FL; k++) begin
      @(negedge clock);
      chk("churn_laser", laser_out, pat_3c[(k-1)/CPB]);
      chk("churn_ready", data_ready, k == FL);
      if (k < FL - 1) data_in = DW'($urandom);
      if (k == FL - 1) data_valid = 1'b0;
    end
    $display("frame 3c under input churn checked");

    // Reset during payload bit 3 of 0xFF.
    @(posedge clock); #1;
    data_valid = 1'b1;
    data_in    = 8'hFF;
    @(posedge clock); #1;
    data_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      chk("abort_laser", laser_out, pat_ff[(k-1)/CPB]);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("abort_ready_in_reset", data_ready, 1'b0);
    @(negedge clock);
    chk("abort_laser_off", laser_out, 1'b0);
    chk("abort_busy_off", busy, 1'b0);
    chk("abort_no_done", done, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready_after", data_ready, 1'b1);
    $display("reset abort mid-frame checked");
    run_frame("81", 8'h81, pat_81);

    // Randomized traffic with occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = DW'($urandom);
      reset      = ($urandom_range(0, 299) == 0);
      if (i % 500 == 0) $display("random phase cycle %0d", i);
    end
    @(posedge clock); #1;
    reset      = 1'b0;
    data_valid = 1'b0;
    repeat (2 * FL) @(posedge clock);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_laser_tx

// File: doc/laser_tx.md
LASER_TX -- requirements
Module: laser_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame; SHALL be >= 1.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per line bit; SHALL be >= 2.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  DATA_WIDTH  payload word to transmit.
REQ-006 data_valid  input  1  data_in holds a word offered for transmission.
REQ-007 data_ready  output  1  block can accept a word this cycle.
REQ-008 laser_out  output  1  laser drive; 1 = on, 0 = off.
REQ-009 busy  output  1  a frame is in progress.
REQ-010 done  output  1  single-cycle pulse on the final cycle of a frame.

Function
REQ-011 Handshake SHALL occur on a rising edge where data_valid and data_ready are both 1; data_in SHALL be captured into an internal shift register at that edge.
REQ-012 Frame SHALL be: start bit (1), DATA_WIDTH payload bits LSB first, stop bit (0); idle line level SHALL be 0.
REQ-013 Each line bit SHALL be held for exactly CLKS_PER_BIT cycles; frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-014 laser_out SHALL be registered; the first start-bit cycle SHALL be the cycle immediately after the accepting edge.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on accept; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after DATA_WIDTH bit periods; STOP->IDLE after CLKS_PER_BIT cycles with no accept, STOP->START with an accept.
REQ-016 data_ready SHALL be 1 in IDLE and during the last cycle of STOP, otherwise 0, and always 0 while reset is 1.
REQ-017 Accept during the last STOP cycle SHALL start the next start bit the following cycle, with no idle gap (back-to-back).
REQ-018 busy SHALL be 1 exactly when state != IDLE.
REQ-019 done SHALL be 1 only during the last cycle of STOP, regardless of whether a back-to-back accept occurs.
REQ-020 data_valid or data_in changes while data_ready=0 SHALL have no effect on the frame in progress.
REQ-021 Bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, counting 0..CLKS_PER_BIT-1 and wrapping to 0; bit index counter SHALL be $clog2(DATA_WIDTH+1) bits wide.

Reset
REQ-022 While reset=1 at a rising edge: state=IDLE, laser_out=0, busy=0, done=0, counters=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame without a done pulse; laser_out SHALL be 0 from the cycle after the reset edge.
REQ-024 After reset deasserts, data_ready SHALL be 1 in the first cycle.

Structure
REQ-025 Package laser_pkg SHALL hold the tx_state_t enum (IDLE, START, DATA, STOP) and constants LASER_IDLE=0, LASER_START=1, LASER_STOP=0.
REQ-026 Sub-module laser_tx_bit_timer SHALL provide the bit-period counter, with inputs clock, reset, restart and output bit_tick (high on the last cycle of each bit period).
REQ-027 laser_tx SHALL contain only the FSM, shift register, bit index counter and output registers, plus one laser_tx_bit_timer instance.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-028 Reset for 2 cycles, then idle -> laser_out=0, busy=0, done=0, data_ready=1.
REQ-029 Send 0xA5 -> laser_out 1,1,0,1,0,0,1,0,1,0, each held 4 cycles (40 cycles); done high on cycle 40 only; busy low on cycle 41.
REQ-030 data_valid held with 0x00 then 0xFF -> second start bit begins the cycle after the first frame's last stop cycle; 80 contiguous cycles; two done pulses, at cycles 40 and 80.
REQ-031 Accept 0x3C, then toggle data_in randomly with data_valid=1 mid-frame -> waveform matches 0x3C exactly; data_ready=0 except the last STOP cycle.
REQ-032 Send 0xFF, assert reset during payload bit 3 -> laser_out=0 and busy=0 the next cycle, no done pulse; after release, 0x81 transmits correctly.
